// File: rtl/billiard_pkg.sv
// Shared definitions for the cue-ball motion unit.
//   VELOCITY_LIMIT    : largest ball speed, fixed-point units per frame
//   FIXED_POINT_SHIFT : fraction bits of the Q1.6 direction table
//   ANGLE_BITS        : width of the aim direction index (64 directions)
//   cue_state_t       : states of the cue strike controller
package billiard_pkg;

    localparam int VELOCITY_LIMIT    = 200;
    localparam int FIXED_POINT_SHIFT = 6;
    localparam int ANGLE_BITS        = 6;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        CHARGE,
        CALC,
        STRIKE,
        WAIT_MOVE
    } cue_state_t;

endpackage

// File: rtl/cue_dir_lut.sv
// Direction lookup: aim index -> signed Q1.6 cosine and sine (peak +/-64).
//   aimAngle in  6  direction index, 0=+X, 16=+Y (screen down), 32=-X, 48=-Y
//   cosVal   out 8  signed cos of the direction
//   sinVal   out 8  signed sin of the direction
// Only the first quadrant (17 points, 0..90 degrees) is stored; the other
// three quadrants are produced by swapping and negating cos/sin.
module cue_dir_lut
    import billiard_pkg::*;
(
    input  logic [ANGLE_BITS-1:0] aimAngle,
    output logic signed [7:0]     cosVal,
    output logic signed [7:0]     sinVal
);

    // cos(idx * 90deg / 16) * 64, rounded; sin(idx) is quarter(16 - idx).
    function automatic logic [6:0] quarter(input logic [4:0] idx);
        case (idx)
            5'd0:    quarter = 7'd64;
            5'd1:    quarter = 7'd64;
            5'd2:    quarter = 7'd63;
            5'd3:    quarter = 7'd61;
            5'd4:    quarter = 7'd59;
            5'd5:    quarter = 7'd56;
            5'd6:    quarter = 7'd53;
            5'd7:    quarter = 7'd49;
            5'd8:    quarter = 7'd45;
            5'd9:    quarter = 7'd41;
            5'd10:   quarter = 7'd36;
            5'd11:   quarter = 7'd30;
            5'd12:   quarter = 7'd24;
            5'd13:   quarter = 7'd19;
            5'd14:   quarter = 7'd12;
            5'd15:   quarter = 7'd6;
            5'd16:   quarter = 7'd0;
            default: quarter = 7'd0;
        endcase
    endfunction

    logic [4:0]       offset;
    logic signed [7:0] mag_a;   // cos of the in-quadrant offset
    logic signed [7:0] mag_b;   // sin of the in-quadrant offset

    always_comb begin
        offset = {1'b0, aimAngle[3:0]};
        mag_a  = $signed({1'b0, quarter(offset)});
        mag_b  = $signed({1'b0, quarter(5'd16 - offset)});
        cosVal = mag_a;
        sinVal = mag_b;
        case (aimAngle[5:4])
            2'd0: begin cosVal =  mag_a; sinVal =  mag_b; end
            2'd1: begin cosVal = -mag_b; sinVal =  mag_a; end
            2'd2: begin cosVal = -mag_a; sinVal = -mag_b; end
            2'd3: begin cosVal =  mag_b; sinVal = -mag_a; end
            default: begin cosVal = mag_a; sinVal = mag_b; end
        endcase
    end

endmodule

// File: rtl/cue_strike_ctrl.sv
// Cue strike controller: turns player keys into a single shot on the cue ball.
//   clk, reset           system clock, synchronous active-high reset
//   startOfFrame         1-cycle strobe per video frame; keys are sampled only on it
//   allBallsStopped      table is still
//   keyRotCW/keyRotCCW   level: rotate aim +1 / -1
//   keyShoot             level: held = charge, release = strike
//   velocityWriteEnable  1-cycle strike pulse; outVelocityX/Y valid only with it, else 0
//   aimAngle, power      aim direction index and current charge (also drive sprites)
//   cueActive            high in AIM/CHARGE
// There is no backpressure: the strike pulse is a fire-and-forget write, the
// cue ball always accepts it in the cycle it is presented.
module cue_strike_ctrl
    import billiard_pkg::*;
#(
    parameter int MAX_POWER     = VELOCITY_LIMIT,
    parameter int POWER_STEP    = 4,
    parameter int ROT_FRAMES    = 3,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic                  allBallsStopped,
    input  logic                  keyRotCW,
    input  logic                  keyRotCCW,
    input  logic                  keyShoot,
    output logic                  velocityWriteEnable,
    output logic signed [10:0]    outVelocityX,
    output logic signed [10:0]    outVelocityY,
    output logic [ANGLE_BITS-1:0] aimAngle,
    output logic [7:0]            power,
    output logic                  cueActive
);

    localparam int ROT_W    = $clog2(ROT_FRAMES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

    cue_state_t          state, next_state;
    logic [ROT_W-1:0]    rot_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic signed [15:0]  p_x, p_y;
    logic signed [15:0]  v_x, v_y;
    logic signed [7:0]   cos_val, sin_val;
    logic [8:0]          power_sum;
    logic                rot_one_key;

    cue_dir_lut u_lut (
        .aimAngle (aimAngle),
        .cosVal   (cos_val),
        .sinVal   (sin_val)
    );

    // Floor division by 64 of the Q1.6 product; result always fits 11 bits.
    assign v_x         = p_x >>> FIXED_POINT_SHIFT;
    assign v_y         = p_y >>> FIXED_POINT_SHIFT;
    assign power_sum   = {1'b0, power} + 9'(POWER_STEP);
    assign rot_one_key = keyRotCW ^ keyRotCCW;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state          = state;
        velocityWriteEnable = 1'b0;
        outVelocityX        = '0;
        outVelocityY        = '0;
        cueActive           = 1'b0;
        case (state)
            // A shoot key still held from before must be let go before aiming.
            IDLE: if (startOfFrame && allBallsStopped && !keyShoot) next_state = AIM;
            AIM: begin
                cueActive = 1'b1;
                if (startOfFrame && keyShoot && allBallsStopped) next_state = CHARGE;
            end
            CHARGE: begin
                cueActive = 1'b1;
                if (startOfFrame) begin
                    if (!allBallsStopped) next_state = IDLE;
                    else if (!keyShoot)   next_state = (power != 8'd0) ? CALC : AIM;
                end
            end
            CALC: next_state = STRIKE;
            STRIKE: begin
                velocityWriteEnable = 1'b1;
                outVelocityX        = v_x[10:0];
                outVelocityY        = v_y[10:0];
                next_state          = WAIT_MOVE;
            end
            // Waiting a few frames lets the struck ball report motion before a
            // still table is trusted; a zero-velocity strike also ends here.
            WAIT_MOVE: begin
                if (startOfFrame && allBallsStopped && settle_cnt == SETTLE_W'(SETTLE_FRAMES))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aimAngle   <= '0;
            power      <= '0;
            rot_cnt    <= '0;
            settle_cnt <= '0;
            p_x        <= '0;
            p_y        <= '0;
        end else begin
            // Aim rotation: one step per ROT_FRAMES frames of a single held key.
            if (state != AIM) begin
                rot_cnt <= '0;
            end else if (startOfFrame) begin
                if (!rot_one_key) begin
                    rot_cnt <= '0;
                end else if (rot_cnt == ROT_W'(ROT_FRAMES - 1)) begin
                    rot_cnt  <= '0;
                    aimAngle <= keyRotCW ? aimAngle + 1'b1 : aimAngle - 1'b1;
                end else begin
                    rot_cnt <= rot_cnt + 1'b1;
                end
            end

            case (state)
                AIM: if (startOfFrame && keyShoot && allBallsStopped) power <= 8'(POWER_STEP);
                CHARGE: begin
                    if (startOfFrame) begin
                        if (!allBallsStopped) power <= '0;
                        else if (keyShoot)
                            power <= (power_sum >= 9'(MAX_POWER)) ? 8'(MAX_POWER) : power_sum[7:0];
                    end
                end
                STRIKE: power <= '0;
                default: ;
            endcase

            if (state != WAIT_MOVE)
                settle_cnt <= '0;
            else if (startOfFrame && settle_cnt != SETTLE_W'(SETTLE_FRAMES))
                settle_cnt <= settle_cnt + 1'b1;

            if (state == CALC) begin
                p_x <= $signed({8'd0, power}) * $signed({{8{cos_val[7]}}, cos_val});
                p_y <= $signed({8'd0, power}) * $signed({{8{sin_val[7]}}, sin_val});
            end
        end
    end

endmodule

// File: tb/tb_cue_strike_ctrl.sv
// Directed bench for cue_strike_ctrl: aim, charge, strike, rotate, abort and reset cases.
module tb_cue_strike_ctrl;
    import billiard_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               allBallsStopped = 1'b1;
    logic               keyRotCW = 1'b0;
    logic               keyRotCCW = 1'b0;
    logic               keyShoot = 1'b0;
    logic               velocityWriteEnable;
    logic signed [10:0] outVelocityX, outVelocityY;
    logic [5:0]         aimAngle;
    logic [7:0]         power;
    logic               cueActive;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rel_cyc = 0;
    int          pulse_cnt = 0;
    logic [21:0] exp_q[$];
    logic [21:0] mon_e;

    cue_strike_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .allBallsStopped     (allBallsStopped),
        .keyRotCW            (keyRotCW),
        .keyRotCCW           (keyRotCCW),
        .keyShoot            (keyShoot),
        .velocityWriteEnable (velocityWriteEnable),
        .outVelocityX        (outVelocityX),
        .outVelocityY        (outVelocityY),
        .aimAngle            (aimAngle),
        .power               (power),
        .cueActive           (cueActive)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strike pulse is matched against the expected queue.
    always @(negedge clk) begin
        if (velocityWriteEnable) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("vel_x", $signed(outVelocityX), $signed(mon_e[21:11]));
                check("vel_y", $signed(outVelocityY), $signed(mon_e[10:0]));
                check("strike_latency", cyc - rel_cyc, 2);
            end
        end else begin
            check("vel_x_idle_zero", $signed(outVelocityX), 0);
            check("vel_y_idle_zero", $signed(outVelocityY), 0);
        end
    end

    // Driver tasks
    task automatic frame();
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic arm();
        keyShoot  = 1'b0;
        keyRotCW  = 1'b0;
        keyRotCCW = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cueActive) break;
            frame();
        end
        check("arm_reached_aim", cueActive, 1);
    endtask

    task automatic rotate(input logic cw, input logic ccw, input int n);
        keyRotCW  = cw;
        keyRotCCW = ccw;
        frames(n);
        keyRotCW  = 1'b0;
        keyRotCCW = 1'b0;
    endtask

    task automatic charge(input int n);
        keyShoot = 1'b1;
        frames(n);
    endtask

    task automatic expect_shot(input int x, input int y);
        exp_q.push_back({11'(x), 11'(y)});
    endtask

    task automatic release_shot();
        @(negedge clk);
        keyShoot     = 1'b0;
        startOfFrame = 1'b1;
        rel_cyc      = cyc;
        @(negedge clk) startOfFrame = 1'b0;
        repeat (5) @(negedge clk);
        check("pulse_delivered", exp_q.size(), 0);
        check("power_cleared_after_strike", power, 0);
        check("cue_hidden_after_strike", cueActive, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_vwe", velocityWriteEnable, 0);
        check("reset_angle", aimAngle, 0);
        check("reset_power", power, 0);
        check("reset_cue_active", cueActive, 0);
        reset = 1'b0;
        arm();

        // Angle 0, 25 charge frames -> power 100, strike (100, 0)
        charge(25);
        check("t1_power", power, 100);
        expect_shot(100, 0);
        release_shot();
        arm();

        // Angle 8 -> (70, 70)
        rotate(1'b1, 1'b0, 24);
        check("t2_angle8", aimAngle, 8);
        charge(25);
        expect_shot(70, 70);
        release_shot();
        arm();

        // Angle 40 -> (-71, -71), floor on negatives
        rotate(1'b1, 1'b0, 96);
        check("t2_angle40", aimAngle, 40);
        charge(25);
        check("t2_power", power, 100);
        expect_shot(-71, -71);
        release_shot();
        arm();

        // Rotation: wrap up, CCW wrap down, both keys, counter clearing
        rotate(1'b1, 1'b0, 72);
        check("t3_wrap_up_to_0", aimAngle, 0);
        rotate(1'b0, 1'b1, 2);
        check("t3_ccw_two_frames", aimAngle, 0);
        rotate(1'b0, 1'b1, 1);
        check("t3_ccw_wrap_63", aimAngle, 63);
        rotate(1'b1, 1'b1, 10);
        check("t3_both_keys", aimAngle, 63);
        rotate(1'b1, 1'b0, 2);
        rotate(1'b1, 1'b1, 1);
        rotate(1'b1, 1'b0, 2);
        check("t3_counter_cleared", aimAngle, 63);
        rotate(1'b1, 1'b0, 1);
        check("t3_cw_wrap_0", aimAngle, 0);

        // Saturation at 200, rotation frozen while charging
        keyRotCW = 1'b1;
        charge(100);
        check("t4_power_sat", power, 200);
        check("t4_rot_frozen", aimAngle, 0);
        expect_shot(200, 0);
        release_shot();
        arm();

        // Press and release between frames: no charge frame, no pulse
        @(negedge clk) keyShoot = 1'b1;
        @(negedge clk) keyShoot = 1'b0;
        frame();
        check("t4_no_charge_power", power, 0);
        check("t4_no_charge_aim", cueActive, 1);
        check("t4_no_charge_pulses", pulse_cnt, 4);

        // One charge frame -> smallest strike
        charge(1);
        check("t4_min_power", power, 4);
        expect_shot(4, 0);
        release_shot();
        arm();

        // Table moving: shoot ignored in AIM, abort from CHARGE
        allBallsStopped = 1'b0;
        charge(3);
        check("t5_moving_power", power, 0);
        check("t5_moving_stay_aim", cueActive, 1);
        keyShoot = 1'b0;
        frame();
        allBallsStopped = 1'b1;
        charge(5);
        check("t5_charge_power", power, 20);
        allBallsStopped = 1'b0;
        frame();
        check("t5_abort_idle", cueActive, 0);
        check("t5_abort_power", power, 0);
        keyShoot = 1'b0;
        frame();
        allBallsStopped = 1'b1;
        arm();

        // Reset in CALC discards the strike; held shoot blocks re-arm
        rotate(1'b1, 1'b0, 3);
        check("t6_angle_before_reset", aimAngle, 1);
        charge(10);
        @(negedge clk);
        keyShoot     = 1'b0;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("t6_reset_vwe", velocityWriteEnable, 0);
        check("t6_reset_power", power, 0);
        check("t6_reset_angle", aimAngle, 0);
        check("t6_reset_cue", cueActive, 0);
        keyShoot = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        frames(5);
        check("t6_held_shoot_stays_idle", cueActive, 0);
        keyShoot = 1'b0;
        frame();
        check("t6_rearm_after_release", cueActive, 1);
        repeat (5) @(negedge clk);
        check("total_pulses", pulse_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
